// File: rtl/pci_stripe_pkg.sv
// Shared types for the lane striper: lane count, byte width and the FIFO word
// that carries one striped word plus its per-lane fill mask.
package pci_stripe_pkg;
  localparam int WIDTH = 8;
  localparam int LANES = 4;

  typedef logic [LANES-1:0] lane_mask_t;

  typedef struct packed {
    logic [LANES-1:0][WIDTH-1:0] data;
    lane_mask_t                  mask;
  } stripe_word_t;
endpackage

// File: rtl/lane_striper_4l_if.sv
// Byte-stream input and 4-lane output bundle of the lane striper.
interface lane_striper_4l_if #(parameter int DEPTH = 4);
  import pci_stripe_pkg::*;

  logic [WIDTH-1:0]         data_in;
  logic                     valid_in;
  logic                     ready_in;
  logic                     flush;
  logic                     out_ready;
  logic [WIDTH-1:0]         lane_data0;
  logic [WIDTH-1:0]         lane_data1;
  logic [WIDTH-1:0]         lane_data2;
  logic [WIDTH-1:0]         lane_data3;
  logic                     lane_valid0;
  logic                     lane_valid1;
  logic                     lane_valid2;
  logic                     lane_valid3;
  logic [$clog2(DEPTH):0]   fifo_level;

  // Striper side
  modport slave (
    input  data_in, valid_in, flush, out_ready,
    output ready_in, lane_data0, lane_data1, lane_data2, lane_data3,
           lane_valid0, lane_valid1, lane_valid2, lane_valid3, fifo_level
  );

  // Upstream/downstream side
  modport master (
    output data_in, valid_in, flush, out_ready,
    input  ready_in, lane_data0, lane_data1, lane_data2, lane_data3,
           lane_valid0, lane_valid1, lane_valid2, lane_valid3, fifo_level
  );
endinterface

// File: rtl/stripe_word_fifo.sv
// Synchronous FIFO of striped words. Writes while full and reads while empty
// are dropped internally, so the level can never leave 0..DEPTH.
module stripe_word_fifo
  import pci_stripe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_1,
  input  logic                   reset,
  input  logic                   push,
  input  stripe_word_t           wrWord,
  input  logic                   pop,
  output stripe_word_t           rdWord,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  stripe_word_t  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign rdWord = mem[rdPtr];

  // Storage, pointers (power-of-2 depth, so they wrap naturally) and occupancy
  always_ff @(posedge clk_1 or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wrWord;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/lane_striper_4l.sv
// Stripes a serial byte stream across 4 lanes: byte k lands on lane k mod 4.
// Completed (or flushed partial) words queue in a small FIFO and are presented
// on registered lane outputs whenever downstream is ready.
module lane_striper_4l
  import pci_stripe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_1,
  input  logic reset,
  lane_striper_4l_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [1:0]                  lanePtr;
  logic [LANES-1:0][WIDTH-1:0] asmData;
  lane_mask_t                  asmMask;
  logic                        xfer;
  logic                        flushGo;
  logic                        push;
  logic                        fifoFull;
  logic                        fifoEmpty;
  logic [LW-1:0]               fifoLevel;
  stripe_word_t                pushWord;
  stripe_word_t                headWord;
  logic [LANES-1:0][WIDTH-1:0] laneData;
  lane_mask_t                  laneValid;

  // Full means level == DEPTH, so this is the level < DEPTH acceptance test.
  assign bus.ready_in   = ~fifoFull;
  assign bus.fifo_level = fifoLevel;

  assign xfer    = bus.valid_in & bus.ready_in;
  // A flush only closes a word that has at least one byte (held or arriving now).
  assign flushGo = bus.flush & bus.ready_in & ((lanePtr != 2'd0) | xfer);
  assign push    = (xfer & (lanePtr == 2'd3)) | flushGo;

  // Word written to the FIFO: assembly regs with the same-cycle byte merged in
  always_comb begin
    pushWord.data = asmData;
    pushWord.mask = asmMask;
    if (xfer) begin
      pushWord.data[lanePtr] = bus.data_in;
      pushWord.mask[lanePtr] = 1'b1;
    end
  end

  // Assembly: collect bytes lane by lane, clear everything once the word is pushed
  always_ff @(posedge clk_1 or negedge reset) begin
    if (!reset) begin
      lanePtr <= '0;
      asmData <= '0;
      asmMask <= '0;
    end else if (push) begin
      lanePtr <= '0;
      asmData <= '0;
      asmMask <= '0;
    end else if (xfer) begin
      asmData[lanePtr] <= bus.data_in;
      asmMask[lanePtr] <= 1'b1;
      lanePtr          <= lanePtr + 2'd1;
    end
  end

  stripe_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_1  (clk_1),
    .reset  (reset),
    .push   (push),
    .wrWord (pushWord),
    .pop    (bus.out_ready),
    .rdWord (headWord),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .level  (fifoLevel)
  );

  // Output stage: load the head word on out_ready, blank when nothing is queued
  always_ff @(posedge clk_1 or negedge reset) begin
    if (!reset) begin
      laneData  <= '0;
      laneValid <= '0;
    end else if (bus.out_ready) begin
      if (!fifoEmpty) begin
        for (int i = 0; i < LANES; i++)
          laneData[i] <= headWord.mask[i] ? headWord.data[i] : '0;
        laneValid <= headWord.mask;
      end else begin
        laneData  <= '0;
        laneValid <= '0;
      end
    end
  end

  assign bus.lane_data0  = laneData[0];
  assign bus.lane_data1  = laneData[1];
  assign bus.lane_data2  = laneData[2];
  assign bus.lane_data3  = laneData[3];
  assign bus.lane_valid0 = laneValid[0];
  assign bus.lane_valid1 = laneValid[1];
  assign bus.lane_valid2 = laneValid[2];
  assign bus.lane_valid3 = laneValid[3];
endmodule
